// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the two-entry skid register: state encoding and occupancy width.
package pipe_skid_reg_pkg;

    localparam int OCC_BITS = 2;

    // Encoding chosen so the state value is also the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [OCC_BITS-1:0] occ_of(input skid_state_e st);
        return OCC_BITS'(st);
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between an upstream producer, the skid register and a downstream consumer.
interface pipe_skid_reg_if #(
    parameter int DATA_BITS = 32
);
    logic                                     flush;
    logic                                     in_valid;
    logic                                     in_ready;
    logic [DATA_BITS-1:0]                     in_data;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [DATA_BITS-1:0]                     out_data;
    logic [pipe_skid_reg_pkg::OCC_BITS-1:0]   occupancy;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_data_reg.sv
// Load-enable payload register with synchronous active-low reset to a fixed value.
module pipe_data_reg #(
    parameter int                   DATA_BITS   = 32,
    parameter logic [DATA_BITS-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] d,
    output logic [DATA_BITS-1:0] q
);
    logic [DATA_BITS-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= RESET_VALUE;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: full-throughput valid/ready stage with every output driven from a flop.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                   DATA_BITS   = 32,
    parameter logic [DATA_BITS-1:0] RESET_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst,
    pipe_skid_reg_if.slave bus
);
    skid_state_e          state_reg, state_next;
    logic                 in_ready_reg, out_valid_reg;
    logic [OCC_BITS-1:0]  occ_reg;

    logic                 in_fire, out_fire;
    logic                 main_load, skid_load;
    logic [DATA_BITS-1:0] main_d, skid_d, main_q, skid_q;

    assign in_fire  = bus.in_valid & in_ready_reg;
    assign out_fire = out_valid_reg & bus.out_ready;

    always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = bus.in_data;
        skid_d     = bus.in_data;
        if (bus.flush) begin
            // Flush wins over any transfer; an accepted input beat is dropped.
            state_next = ST_EMPTY;
            main_load  = 1'b1;
            skid_load  = 1'b1;
            main_d     = RESET_VALUE;
            skid_d     = RESET_VALUE;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load  = 1'b1;
                        state_next = ST_FULL;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load  = 1'b1;
                        main_d     = skid_q;
                        state_next = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Status outputs are registered from the next state so they never depend on inputs combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            occ_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != ST_FULL);
            out_valid_reg <= (state_next != ST_EMPTY);
            occ_reg       <= occ_of(state_next);
        end
    end

    pipe_data_reg #(
        .DATA_BITS   (DATA_BITS),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_data_reg #(
        .DATA_BITS   (DATA_BITS),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (skid_d),
        .q    (skid_q)
    );

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ_reg;
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_BITS, default 32, payload width in bits (>=1).
REQ-002 Parameter RESET_VALUE, default 0, the value loaded into both data registers on reset and on flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low; 0 at a rising edge of clk resets the block.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream has a beat on in_data.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  DATA_BITS  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  downstream accepts the beat this cycle.
REQ-011 out_data  output  DATA_BITS  downstream payload.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 A transfer occurs on the input side when in_valid=1 and in_ready=1 at a rising edge (in_fire).
REQ-014 A transfer occurs on the output side when out_valid=1 and out_ready=1 at a rising edge (out_fire).
REQ-015 Storage: main register (drives out_data) and skid register; states EMPTY (0 entries), ONE (main only), FULL (main and skid).
REQ-016 in_ready, out_valid, out_data and occupancy are driven directly from flops; no combinational path from any input to any output.
REQ-017 in_ready=1 in EMPTY and ONE; in_ready=0 in FULL.
REQ-018 out_valid=1 in ONE and FULL; out_valid=0 in EMPTY.
REQ-019 EMPTY, in_fire: main<=in_data, go to ONE.
REQ-020 ONE, in_fire and out_fire: main<=in_data, stay in ONE (one beat per cycle sustained).
REQ-021 ONE, in_fire and no out_fire: skid<=in_data, go to FULL.
REQ-022 ONE, out_fire and no in_fire: go to EMPTY; main keeps its last value.
REQ-023 FULL, out_fire: main<=skid, go to ONE.
REQ-024 No fire in any state: all registers hold.
REQ-025 Latency: a beat accepted at edge N is presented on out_data with out_valid=1 after edge N when EMPTY beforehand.
REQ-026 Ordering: beats leave in acceptance order; no beat is duplicated or lost except by flush or reset.
REQ-027 flush=1 at an edge has priority over every transfer: go to EMPTY, main and skid <= RESET_VALUE, occupancy<=0.
REQ-028 A beat presented with in_fire during a flush cycle is discarded; a beat presented with out_fire during a flush cycle counts as consumed.
REQ-029 occupancy equals 0/1/2 for EMPTY/ONE/FULL in the same cycle.
REQ-030 out_data is don't-care while out_valid=0, except that it equals RESET_VALUE after reset or flush until the next load.

Reset
REQ-031 rst=0 at an edge: state EMPTY, in_ready=1, out_valid=0, occupancy=0, main=skid=RESET_VALUE, out_data=RESET_VALUE.
REQ-032 Reset has priority over flush and all transfers; reset mid-operation drops all held beats.
REQ-033 in_ready=1 in the first cycle after reset is released.

Structure
REQ-034 The state encoding (EMPTY/ONE/FULL enumerated type) and the occupancy width constant belong in the shared CPU package.
REQ-035 One sub-module, pipe_data_reg: a DATA_BITS load-enable register with synchronous active-low reset to RESET_VALUE.
REQ-036 pipe_data_reg is instantiated twice, once as main and once as skid.

Verification
REQ-037 Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-038 Streaming: out_ready=1, feed 0x1,0x2,0x3 back-to-back -> out_data 0x1,0x2,0x3 on consecutive cycles, each one cycle after acceptance, occupancy stays 1.
REQ-039 Backpressure: out_ready=0, send 0xA then 0xB -> occupancy=2, in_ready=0 and 0xC is held off; raise out_ready -> 0xA, 0xB, 0xC delivered in order, none lost.
REQ-040 Flush in FULL with in_valid=1 (0xD) -> next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE, 0xD is never output.
REQ-041 Reset mid-stream in state ONE with 0x55 held -> 0x55 is never output and the block returns to the REQ-031 state.
REQ-042 Randomized valid/ready against a reference queue for DATA_BITS=1 and DATA_BITS=64 -> identical output sequence, occupancy never exceeds 2.
